dsm_serial_core: RTL

Parametrised, time-multiplexed delta-sigma modulator core: an ORDER-state loop filter in controllable-canonical form, evaluated by one serial multiply-accumulate pass per input sample, feeding a 1-bit quantizer. Loop coefficients are runtime-programmable, arithmetic saturates instead of wrapping, and saturation events are counted. The core sits between the sample source and the PWM output stage and replaces the fixed fourth-order modulator.

---
 rtl/dsm_pkg.sv | 66 ++++++
 rtl/dsm_sat_shift.sv | 30 +++
 rtl/dsm_serial_core.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dsm_pkg.sv
// dsm_pkg -- shared definitions for the serial delta-sigma modulator core.
//
// Contents:
//   state_t       FSM states of the serial evaluation (IDLE -> MAC -> FIN)
//   coefficient   address map helpers (A0[i], C[i], D)
//   fs / fs_half  full-scale derivation from the fractional bit count
//   saturate      clamp a wide signed value into a w-bit signed range
//   LFSR_SEED/TAPS dither generator constants (only with DSM_DITHER_EN)
//
// Configuration macro: DSM_DITHER_EN (enables the dither LFSR constants).
package dsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Coefficient address map: A0[i] at i, C[i] at ORDER+i, D at 2*ORDER.
    localparam int COEF_A_BASE = 0;

    function automatic int coef_a_addr(input int i);
        return COEF_A_BASE + i;
    endfunction

    function automatic int coef_c_addr(input int order, input int i);
        return order + i;
    endfunction

    function automatic int coef_d_addr(input int order);
        return 2 * order;
    endfunction

    // Full scale is 2^FRAC; the quantizer feedback is +/- half of it.
    function automatic longint fs(input int frac);
        return longint'(1) << frac;
    endfunction

    function automatic longint fs_half(input int frac);
        return fs(frac) >>> 1;
    endfunction

    // Clamp v into [-2^(w-1), 2^(w-1)-1]; callers compare the result with v
    // to detect that clamping happened.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

`ifdef DSM_DITHER_EN
    // Right-shifting Fibonacci form of taps 16,14,13,11: feedback is the
    // XOR of bits 0,2,3,5, inserted at bit 15.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
`endif

endpackage

// File: rtl/dsm_sat_shift.sv
// dsm_sat_shift -- combinational arithmetic right shift plus signed
// saturation.
//
// Ports:
//   din   in  IW  signed wide value (accumulator or sum)
//   dout  out OW  signed, (din >>> SHIFT) clamped to OW bits
//   ovf   out 1   clamping was applied
//
// The shift rounds toward -inf (plain truncation of the two's complement
// value). IW must stay below 64.
module dsm_sat_shift #(
    parameter int IW    = 49,
    parameter int OW    = 20,
    parameter int SHIFT = 23
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 ovf
);
    import dsm_pkg::*;

    logic signed [63:0] shifted;
    logic signed [63:0] clamped;

    assign shifted = 64'(din) >>> SHIFT;
    assign clamped = saturate(shifted, OW);
    assign dout    = clamped[OW-1:0];
    assign ovf     = (clamped != shifted);

endmodule

// File: rtl/dsm_serial_core.sv
// dsm_serial_core -- time-multiplexed delta-sigma modulator.
//
// An ORDER-state loop filter in controllable-canonical form is evaluated by
// one multiply-accumulate per clock (A0[i]*x[i] into a, C[i]*x[i] into c),
// followed by a finish cycle that adds the input terms, saturates, shifts
// the state chain and updates the 1-bit quantizer. One sample per ORDER+2
// clocks.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   vin_valid/vin  input sample offer (signed DW bits)
//   vin_ready      high while idle; sample taken on vin_valid && vin_ready
//   coef_we/addr/wdata  coefficient write, honoured only while idle:
//                  0..ORDER-1 = A0[i], ORDER..2*ORDER-1 = C[i], 2*ORDER = D
//                  (D is reachable through the 4-bit address for ORDER <= 7)
//   sat_clr        clears sat_count, overriding a same-cycle increment
//   pwm            quantizer output
//   pwm_valid      one-cycle pulse after each pwm update
//   sat_count      saturating count of samples in which any clamp occurred
//
// Configuration macro: DSM_DITHER_EN adds a 16-bit LFSR whose low byte,
// taken as signed, is added to the quantizer input at data LSB.
module dsm_serial_core #(
    parameter int DW    = 20,
    parameter int FRAC  = 15,
    parameter int CW    = 25,
    parameter int CFRAC = 23,
    parameter int ORDER = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vin_valid,
    input  logic signed [DW-1:0] vin,
    output logic                 vin_ready,
    input  logic                 coef_we,
    input  logic [3:0]           coef_addr,
    input  logic signed [CW-1:0] coef_wdata,
    input  logic                 sat_clr,
    output logic                 pwm,
    output logic                 pwm_valid,
    output logic [15:0]          sat_count
);
    import dsm_pkg::*;

    localparam int AW    = DW + CW + 4;   // accumulator: cannot wrap
    localparam int SW    = DW + 2;        // y + vin + dither before clamping
    localparam int IDX_W = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(ORDER - 1);
    localparam logic signed [DW:0] FS_HALF = (DW + 1)'(fs_half(FRAC));

    state_t state;
    state_t state_next;
    logic   accept;
    logic   coef_write;
    logic   fin;

    logic [IDX_W-1:0]     idx;
    logic signed [DW-1:0] vin_q;
    logic signed [DW:0]   u_q;
    logic signed [DW:0]   u_next;
    logic signed [AW-1:0] acc_a;
    logic signed [AW-1:0] acc_c;
    logic signed [AW-1:0] prod_a;
    logic signed [AW-1:0] prod_c;
    logic signed [AW-1:0] fin_a;
    logic signed [AW-1:0] fin_c;

    logic signed [CW-1:0] a0 [ORDER];
    logic signed [CW-1:0] cc [ORDER];
    logic signed [CW-1:0] d_coef;
    logic signed [DW-1:0] x  [ORDER];

    logic signed [DW-1:0] x_new;
    logic signed [DW-1:0] y;
    logic signed [DW-1:0] s;
    logic signed [SW-1:0] s_sum;
    logic signed [7:0]    dither;
    logic                 ovf_a;
    logic                 ovf_c;
    logic                 ovf_s;
    logic                 pwm_next;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: every flop uses <= so all of them see the pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first -- any path that skips an assignment would
        // otherwise infer a latch.
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vin_valid) begin
                    accept     = 1'b1;
                    state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                if (idx == IDX_LAST) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign vin_ready  = (state == ST_IDLE);
    assign coef_write = coef_we && (state == ST_IDLE);
    assign fin        = (state == ST_FIN);

    // ---------------- coefficient bank ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the bank is a handful of flops, not a RAM, so it is
            // cleared by reset like any other register.
            for (int i = 0; i < ORDER; i++) begin
                a0[i] <= '0;
                cc[i] <= '0;
            end
            d_coef <= '0;
        end else if (coef_write) begin
            for (int i = 0; i < ORDER; i++) begin
                if (int'(coef_addr) == coef_a_addr(i)) a0[i] <= coef_wdata;
                if (int'(coef_addr) == coef_c_addr(ORDER, i)) cc[i] <= coef_wdata;
            end
            if (int'(coef_addr) == coef_d_addr(ORDER)) d_coef <= coef_wdata;
        end
    end

    // ---------------- arithmetic ----------------
    // Feedback term uses the quantizer output held at accept time.
    assign u_next = pwm ? ((DW + 1)'(vin) - FS_HALF) : ((DW + 1)'(vin) + FS_HALF);

    assign prod_a = AW'(a0[idx]) * AW'(x[idx]);
    assign prod_c = AW'(cc[idx]) * AW'(x[idx]);

    // u enters a at coefficient scale so both accumulators share one shift.
    assign fin_a = acc_a + (AW'(u_q) <<< CFRAC);
    assign fin_c = acc_c + AW'(d_coef) * AW'(u_q);

    dsm_sat_shift #(.IW(AW), .OW(DW), .SHIFT(CFRAC)) u_sat_a (
        .din (fin_a),
        .dout(x_new),
        .ovf (ovf_a)
    );

    dsm_sat_shift #(.IW(AW), .OW(DW), .SHIFT(CFRAC)) u_sat_c (
        .din (fin_c),
        .dout(y),
        .ovf (ovf_c)
    );

    assign s_sum = SW'(y) + SW'(vin_q) + SW'(dither);

    dsm_sat_shift #(.IW(SW), .OW(DW), .SHIFT(0)) u_sat_s (
        .din (s_sum),
        .dout(s),
        .ovf (ovf_s)
    );

    assign pwm_next = (s >= DW'(0));

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            vin_q     <= '0;
            u_q       <= '0;
            acc_a     <= '0;
            acc_c     <= '0;
            pwm       <= 1'b0;
            pwm_valid <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                x[k] <= '0;
            end
        end else begin
            pwm_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        vin_q <= vin;
                        u_q   <= u_next;
                        acc_a <= '0;
                        acc_c <= '0;
                        idx   <= '0;
                    end
                end
                ST_MAC: begin
                    acc_a <= acc_a + prod_a;
                    acc_c <= acc_c + prod_c;
                    idx   <= idx + 1'b1;
                end
                ST_FIN: begin
                    x[0] <= x_new;
                    for (int k = 1; k < ORDER; k++) begin
                        x[k] <= x[k-1];
                    end
                    pwm       <= pwm_next;
                    pwm_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- saturation counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (fin && (ovf_a || ovf_c || ovf_s) && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

    // ---------------- dither ----------------
`ifdef DSM_DITHER_EN
    logic [15:0] lfsr;

    // The current low byte dithers this FIN; the LFSR then advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (fin) begin
            lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
        end
    end

    assign dither = lfsr[7:0];
`else
    assign dither = '0;
`endif

endmodule
